// File: rtl/ct_read_arbiter.sv
// Single-port ciphertext memory arbiter: the loader writes with fixed priority,
// and the two crack-core readers share the remaining cycles round-robin with tagged read return.
module ct_read_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_gnt,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_gnt,
    output logic              r0_valid,
    output logic [DATA_W-1:0] r0_data,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_gnt,
    output logic              r1_valid,
    output logic [DATA_W-1:0] r1_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wrdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rddata
);

    logic last_rd_r;
    logic pend_vld_r;
    logic pend_id_r;
    logic w_gnt_s;
    logic r0_gnt_s;
    logic r1_gnt_s;

    // Grant selection: writer first, then the single requester, then the reader not served last.
    always_comb begin
        w_gnt_s  = 1'b0;
        r0_gnt_s = 1'b0;
        r1_gnt_s = 1'b0;
        if (rst) begin
            w_gnt_s  = 1'b0;
        end else if (w_req) begin
            w_gnt_s  = 1'b1;
        end else if (r0_req && r1_req) begin
            if (last_rd_r) begin
                r0_gnt_s = 1'b1;
            end else begin
                r1_gnt_s = 1'b1;
            end
        end else if (r0_req) begin
            r0_gnt_s = 1'b1;
        end else if (r1_req) begin
            r1_gnt_s = 1'b1;
        end else begin
            w_gnt_s  = 1'b0;
        end
    end

    // Memory port drive from the winning client; idle cycles park the bus at zero.
    always_comb begin
        mem_addr   = {ADDR_W{1'b0}};
        mem_wrdata = {DATA_W{1'b0}};
        mem_wren   = 1'b0;
        case ({w_gnt_s, r0_gnt_s, r1_gnt_s})
            3'b100: begin
                mem_addr   = w_addr;
                mem_wrdata = w_data;
                mem_wren   = 1'b1;
            end
            3'b010: begin
                mem_addr   = r0_addr;
            end
            3'b001: begin
                mem_addr   = r1_addr;
            end
            default: begin
                mem_addr   = {ADDR_W{1'b0}};
                mem_wrdata = {DATA_W{1'b0}};
                mem_wren   = 1'b0;
            end
        endcase
    end

    // Round-robin history and read-return tag; last_rd starts at 1 so reader 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_rd_r  <= 1'b1;
            pend_vld_r <= 1'b0;
            pend_id_r  <= 1'b0;
        end else begin
            pend_vld_r <= r0_gnt_s | r1_gnt_s;
            pend_id_r  <= r1_gnt_s;
            if (r0_gnt_s || r1_gnt_s) begin
                last_rd_r <= r1_gnt_s;
            end else begin
                last_rd_r <= last_rd_r;
            end
        end
    end

    assign w_gnt  = w_gnt_s;
    assign r0_gnt = r0_gnt_s;
    assign r1_gnt = r1_gnt_s;

    // A read granted just before reset must not strobe during the reset cycle.
    assign r0_valid = pend_vld_r & ~pend_id_r & ~rst;
    assign r1_valid = pend_vld_r &  pend_id_r & ~rst;
    assign r0_data  = mem_rddata;
    assign r1_data  = mem_rddata;

endmodule

// File: tb/tb_ct_read_arbiter.sv
// Scoreboard bench for ct_read_arbiter: a reference arbiter and memory shadow predict
// grants each cycle and queue the expected read return for the following cycle.
module tb_ct_read_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_req;
    logic [7:0] w_addr;
    logic [7:0] w_data;
    logic       w_gnt;
    logic       r0_req;
    logic [7:0] r0_addr;
    logic       r0_gnt;
    logic       r0_valid;
    logic [7:0] r0_data;
    logic       r1_req;
    logic [7:0] r1_addr;
    logic       r1_gnt;
    logic       r1_valid;
    logic [7:0] r1_data;
    logic [7:0] mem_addr;
    logic [7:0] mem_wrdata;
    logic       mem_wren;
    logic [7:0] mem_rddata;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [8:0] sb [$];
    logic       m_last;
    int         checks = 0;
    int         errors = 0;

    ct_read_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt),
        .r0_valid(r0_valid), .r0_data(r0_data),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt),
        .r1_valid(r1_valid), .r1_data(r1_data),
        .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wren(mem_wren),
        .mem_rddata(mem_rddata)
    );

    always #5 clk = ~clk;

    // ct_mem stand-in: 256x8 single port, one-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_wrdata;
        mem_rddata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: check at negedge against the reference model, then advance past posedge.
    task automatic step();
        logic       ew;
        logic       e0;
        logic       e1;
        logic [8:0] ent;
        @(negedge clk);
        if (rst) sb.delete();
        if (sb.size() > 0) begin
            ent = sb.pop_front();
            chk("r0_valid", 32'(r0_valid), 32'(!ent[8]));
            chk("r1_valid", 32'(r1_valid), 32'(ent[8]));
            if (ent[8]) chk("r1_data", 32'(r1_data), 32'(ent[7:0]));
            else        chk("r0_data", 32'(r0_data), 32'(ent[7:0]));
        end else begin
            chk("r0_valid_idle", 32'(r0_valid), 32'd0);
            chk("r1_valid_idle", 32'(r1_valid), 32'd0);
        end
        ew = !rst && w_req;
        e0 = !rst && !w_req && r0_req && (!r1_req || m_last);
        e1 = !rst && !w_req && r1_req && (!r0_req || !m_last);
        chk("w_gnt", 32'(w_gnt), 32'(ew));
        chk("r0_gnt", 32'(r0_gnt), 32'(e0));
        chk("r1_gnt", 32'(r1_gnt), 32'(e1));
        chk("mem_wren", 32'(mem_wren), 32'(ew));
        chk("mem_addr", 32'(mem_addr), ew ? 32'(w_addr) : e0 ? 32'(r0_addr) : e1 ? 32'(r1_addr) : 32'd0);
        if (ew)            chk("mem_wrdata", 32'(mem_wrdata), 32'(w_data));
        else if (!e0 && !e1) chk("mem_wrdata_idle", 32'(mem_wrdata), 32'd0);
        if (rst) m_last = 1'b1;
        if (ew) ref_mem[w_addr] = w_data;
        if (e0) begin
            sb.push_back({1'b0, ref_mem[r0_addr]});
            m_last = 1'b0;
        end
        if (e1) begin
            sb.push_back({1'b1, ref_mem[r1_addr]});
            m_last = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end
        mem[5]     = 8'hA7;
        ref_mem[5] = 8'hA7;
        m_last  = 1'b1;
        rst     = 1'b1;
        w_req   = 1'b0; w_addr  = 8'h00; w_data = 8'h00;
        r0_req  = 1'b0; r0_addr = 8'h00;
        r1_req  = 1'b0; r1_addr = 8'h00;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;

        // Single read of 0x05.
        r0_req = 1'b1; r0_addr = 8'h05;
        step();
        r0_req = 1'b0;
        step(); step();

        // Contention from a fresh reset: r0, r1 alternate.
        rst = 1'b1; step(); rst = 1'b0;
        r0_req = 1'b1; r0_addr = 8'h10;
        r1_req = 1'b1; r1_addr = 8'h20;
        repeat (6) step();

        // Writer beats both readers; the tie afterwards still goes to r0.
        w_req = 1'b1; w_addr = 8'h03; w_data = 8'h5C;
        step();
        w_req = 1'b0; r0_addr = 8'h03;
        step();
        r0_req = 1'b0; r1_req = 1'b0;
        step(); step();

        // r1 back-to-back reads.
        r1_req = 1'b1;
        for (int a = 0; a < 3; a++) begin
            r1_addr = 8'(a);
            step();
        end
        r1_req = 1'b0;
        step(); step();

        // Read granted just before reset never strobes; requests ignored in reset.
        r0_req = 1'b1; r0_addr = 8'h05;
        step();
        rst = 1'b1; w_req = 1'b1; r1_req = 1'b1;
        step(); step();
        rst = 1'b0; w_req = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
        step(); step();

        // Idle.
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
